// File: rtl/vga_timing_ctrl.sv
// VGA timing and mode controller: pixel/line counters, sync strobes and active-region
// margins, with new video modes accepted by handshake and applied only at a frame boundary.
module vga_timing_ctrl #(
    parameter int   REZ_MAX_WIDTH = 11,
    parameter logic SYNC_POL      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_h_total,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_v_total,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_h_sync_end,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_v_sync_end,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_h_act_start,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_h_act_end,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_v_act_start,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_v_act_end,
    output logic                     cfg_err,
    output logic [REZ_MAX_WIDTH-1:0] Count_h,
    output logic [REZ_MAX_WIDTH-1:0] Count_v,
    output logic [REZ_MAX_WIDTH-1:0] H_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] H_right_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_right_margin,
    output logic                     HSYNC,
    output logic                     VSYNC,
    output logic                     frame_start
);

    localparam logic [REZ_MAX_WIDTH-1:0] ONE = REZ_MAX_WIDTH'(1);
    localparam logic [REZ_MAX_WIDTH-1:0] TWO = REZ_MAX_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    typedef struct packed {
        logic [REZ_MAX_WIDTH-1:0] h_total;
        logic [REZ_MAX_WIDTH-1:0] v_total;
        logic [REZ_MAX_WIDTH-1:0] h_sync_end;
        logic [REZ_MAX_WIDTH-1:0] v_sync_end;
        logic [REZ_MAX_WIDTH-1:0] h_act_start;
        logic [REZ_MAX_WIDTH-1:0] h_act_end;
        logic [REZ_MAX_WIDTH-1:0] v_act_start;
        logic [REZ_MAX_WIDTH-1:0] v_act_end;
    } mode_t;

    state_t                   state_q;
    mode_t                    mode_q, shadow_q, cfg_mode;
    logic [REZ_MAX_WIDTH-1:0] count_h_q, count_v_q, count_h_d, count_v_d;
    logic                     hsync_q, vsync_q, cfg_err_q;
    logic                     h_last, v_last, frame_end, xfer, cfg_ok;

    assign cfg_mode = '{
        h_total:     cfg_h_total,
        v_total:     cfg_v_total,
        h_sync_end:  cfg_h_sync_end,
        v_sync_end:  cfg_v_sync_end,
        h_act_start: cfg_h_act_start,
        h_act_end:   cfg_h_act_end,
        v_act_start: cfg_v_act_start,
        v_act_end:   cfg_v_act_end
    };

    assign cfg_ready = (state_q != PENDING);
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_h_total >= TWO) && (cfg_v_total >= TWO);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        h_last    = (count_h_q == mode_q.h_total - ONE);
        v_last    = (count_v_q == mode_q.v_total - ONE);
        frame_end = h_last && v_last;
        count_h_d = count_h_q + ONE;
        count_v_d = count_v_q;
        if (h_last) begin
            count_h_d = '0;
            count_v_d = v_last ? '0 : count_v_q + ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= IDLE;
            mode_q               <= '0;
            mode_q.h_act_start   <= '1;
            mode_q.v_act_start   <= '1;
            shadow_q             <= '0;
            count_h_q            <= '0;
            count_v_q            <= '0;
            hsync_q              <= ~SYNC_POL;
            vsync_q              <= ~SYNC_POL;
            cfg_err_q            <= 1'b0;
        end else begin
            cfg_err_q <= xfer && !cfg_ok;
            case (state_q)
                IDLE: begin
                    hsync_q <= ~SYNC_POL;
                    vsync_q <= ~SYNC_POL;
                    if (xfer && cfg_ok) begin
                        mode_q  <= cfg_mode;
                        state_q <= RUN;
                    end
                end
                RUN, PENDING: begin
                    count_h_q <= count_h_d;
                    count_v_q <= count_v_d;
                    // Syncs are derived from the current counters, so they lag them by one cycle.
                    hsync_q   <= (count_h_q < mode_q.h_sync_end) ? SYNC_POL : ~SYNC_POL;
                    vsync_q   <= (count_v_q < mode_q.v_sync_end) ? SYNC_POL : ~SYNC_POL;
                    if (state_q == PENDING) begin
                        if (frame_end) begin
                            mode_q  <= shadow_q;
                            state_q <= RUN;
                        end
                    end else if (xfer && cfg_ok) begin
                        if (frame_end) begin
                            mode_q <= cfg_mode;
                        end else begin
                            shadow_q <= cfg_mode;
                            state_q  <= PENDING;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Count_h        = count_h_q;
    assign Count_v        = count_v_q;
    assign H_left_margin  = mode_q.h_act_start;
    assign H_right_margin = mode_q.h_act_end;
    assign V_left_margin  = mode_q.v_act_start;
    assign V_right_margin = mode_q.v_act_end;
    assign HSYNC          = hsync_q;
    assign VSYNC          = vsync_q;
    assign cfg_err        = cfg_err_q;
    assign frame_start    = (state_q == RUN) && (count_h_q == '0) && (count_v_q == '0);

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Timing and configuration controller for the VGA output path. Generates the horizontal/vertical pixel counters, the display-region margins and the HSYNC/VSYNC strobes that drive the colour-assignment stage. Accepts a new video mode through a valid/ready handshake and applies it only at a frame boundary, so no torn frame is ever produced.

## Interface
- REZ_MAX_WIDTH, 11, width of counters, totals and margins
- SYNC_POL, 0, active level of HSYNC/VSYNC (0 = active-low)

- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  new mode offered
- cfg_ready  out  1  controller can accept a mode
- cfg_h_total, cfg_v_total  in  REZ_MAX_WIDTH each  pixels per line, lines per frame
- cfg_h_sync_end, cfg_v_sync_end  in  REZ_MAX_WIDTH each  sync asserted while counter < value
- cfg_h_act_start, cfg_h_act_end  in  REZ_MAX_WIDTH each  inclusive active columns
- cfg_v_act_start, cfg_v_act_end  in  REZ_MAX_WIDTH each  inclusive active lines
- cfg_err  out  1  one-cycle pulse: offered mode rejected
- Count_h, Count_v  out  REZ_MAX_WIDTH each  current pixel and line counters
- H_left_margin, H_right_margin, V_left_margin, V_right_margin  out  REZ_MAX_WIDTH each  active-region bounds of the applied mode
- HSYNC, VSYNC  out  1 each  registered sync strobes
- frame_start  out  1  high while RUN and Count_h = Count_v = 0

## Operation
- States: IDLE (no mode applied), RUN, PENDING (shadow mode waiting for frame end).
- cfg_ready = 1 in IDLE and RUN, 0 in PENDING. Transfer occurs when cfg_valid && cfg_ready.
- Validity: a mode is valid iff h_total ≥ 2 and v_total ≥ 2. An invalid mode is consumed (handshake completes), discarded, and cfg_err pulses the next cycle. State and applied mode are unchanged.
- IDLE + valid transfer: the mode is applied at the next edge. Counters = 0. State goes to RUN.
- RUN + valid transfer on any cycle except the last pixel: the mode is stored in the shadow register and state goes to PENDING.
- RUN + valid transfer on the last pixel (Count_h = h_total-1 and Count_v = v_total-1): the mode is applied directly at that wrap. State stays RUN.
- PENDING: the shadow mode is applied at the edge that wraps the last pixel. State returns to RUN.
- Counters in RUN:
  - Count_h increments every cycle.
  - At Count_h = h_total-1, Count_h wraps to 0 and Count_v increments.
  - At Count_v = v_total-1 on a line wrap, Count_v wraps to 0.
  - Counter arithmetic is unsigned REZ_MAX_WIDTH.
  - The comparisons use the applied mode only. A mode change never alters the current frame.
- Margin outputs present the applied act_start/act_end values.
- In IDLE, counters are held at 0, H_left_margin = all-ones and H_right_margin = 0, so there is no active region.
- Sync:
  - HSYNC_next = SYNC_POL when Count_h < h_sync_end, else ~SYNC_POL. VSYNC is the same using Count_v.
  - In IDLE both are held at ~SYNC_POL.

## Timing
- Reset values:
  - State IDLE, cfg_ready 1, cfg_err 0.
  - Count_h = Count_v = 0, frame_start 0.
  - H_left_margin = V_left_margin = all-ones, H_right_margin = V_right_margin = 0.
  - HSYNC = VSYNC = ~SYNC_POL.
  - Shadow cleared.
- rst mid-frame or in PENDING: everything returns to reset values at that edge. Any pending mode is lost.
- HSYNC/VSYNC are registered from the counters: they lag Count_h/Count_v by one cycle, matching the one-cycle registered active flag of the colour stage.
- Counters and margins are registered; frame_start is combinational from them.
- A mode transferred at edge N in IDLE gives Count_h = 0 and frame_start = 1 in cycle N+1.
- cfg_ready deasserts the cycle after a PENDING transfer and reasserts the cycle after the frame wrap.

## Test plan
- Reset, then no cfg for 20 cycles → counters stay 0, HSYNC = VSYNC = 1, margins 2047/0, frame_start 0.
- Mode h_total=10, v_total=4, h_sync_end=2, v_sync_end=1, act 3..8 / 1..2 → Count_h wraps 9→0 with Count_v incrementing. HSYNC is low for 2 cycles per line, delayed one cycle from Count_h. frame_start pulses every 40 cycles.
- While running mode A, offer mode B (h_total=6) mid-frame → cfg_ready drops next cycle. Mode A completes its frame (last pixel 9,3). Next cycle shows Count_h = 0 with the B margins, and the line wraps at 5.
- Offer mode B exactly on pixel (9,3) → applied at that wrap, cfg_ready stays 1.
- Offer h_total=1 → handshake completes, cfg_err pulses one cycle, and counters/margins are unaffected.
- Assert rst while in PENDING at pixel (5,2) → all reset values next cycle. Subsequent behaviour matches scenario 1.
